// File: rtl/next_pc_unit.sv
// PC register and next-PC select with stall hold, one-deep pending-redirect latch,
// JALR bit-0 clearing, misaligned-target trap and illegal-select flag. Optional: NPC_RVC_EN.
module next_pc_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     NUM_SRC      = 4,
    parameter int unsigned     SEL_W        = 2,
    parameter int unsigned     JALR_IDX     = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall_i,
    input  logic                        redirect_valid_i,
    input  logic [SEL_W-1:0]            sel_i,
    input  logic [(NUM_SRC-1)*XLEN-1:0] tgt_flat_i,
`ifdef NPC_RVC_EN
    input  logic                        is_rvc_i,
`endif
    output logic [XLEN-1:0]             pc_o,
    output logic [XLEN-1:0]             pc_plus4_o,
    output logic                        pc_valid_o,
    output logic                        pend_o,
    output logic                        misalign_o,
    output logic [XLEN-1:0]             bad_addr_o,
    output logic                        sel_err_o
);

    localparam int unsigned      NUM_SLOTS = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] JALR_SEL  = SEL_W'(JALR_IDX);

    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] pending_reg, pending_next;
    logic [XLEN-1:0] bad_addr_reg, bad_addr_next;
    logic            misalign_reg, misalign_next;
    logic            sel_err_reg, sel_err_next;

    logic [XLEN-1:0] tgt_arr [NUM_SLOTS];
    logic [XLEN-1:0] eff_tgt;
    logic [XLEN-1:0] seq_inc;
    logic [XLEN-1:0] load_val;
    logic            load_en;
    logic            sel_too_big;
    logic            sel_in_range;

    // Unused slots (index 0 and any select value past NUM_SRC-1) read as zero.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_tgt
            if (gi >= 1 && gi < NUM_SRC) begin : g_used
                assign tgt_arr[gi] = tgt_flat_i[gi*XLEN-1 -: XLEN];
            end else begin : g_unused
                assign tgt_arr[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        eff_tgt = tgt_arr[sel_i];
        if (sel_i == JALR_SEL) begin
            eff_tgt[0] = 1'b0;
        end
    end

    assign sel_too_big  = (32'(sel_i) >= NUM_SRC);
    assign sel_in_range = (sel_i != '0) && !sel_too_big;

`ifdef NPC_RVC_EN
    assign seq_inc = is_rvc_i ? XLEN'(2) : XLEN'(4);
`else
    assign seq_inc = XLEN'(4);
`endif
    assign pc_plus4_o = pc_reg + seq_inc;

    function automatic logic is_misaligned(input logic [XLEN-1:0] t);
`ifdef NPC_RVC_EN
        return t[0];
`else
        return |t[1:0];
`endif
    endfunction

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        pending_next  = pending_reg;
        bad_addr_next = bad_addr_reg;
        misalign_next = 1'b0;
        sel_err_next  = 1'b0;
        load_en       = 1'b0;
        load_val      = pending_reg;

        case (state_reg)
            BOOT: state_next = RUN;
            RUN: begin
                sel_err_next = redirect_valid_i && sel_too_big;
                if (!stall_i) begin
                    if (redirect_valid_i && sel_in_range) begin
                        load_en  = 1'b1;
                        load_val = eff_tgt;
                    end else begin
                        pc_next = pc_plus4_o;
                    end
                end else if (redirect_valid_i && sel_in_range) begin
                    pending_next = eff_tgt;
                    state_next   = PEND;
                end
            end
            // Oldest redirect wins: inputs are ignored until the latched one is taken.
            PEND: begin
                if (!stall_i) begin
                    load_en    = 1'b1;
                    load_val   = pending_reg;
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase

        if (load_en) begin
            if (is_misaligned(load_val)) begin
                pc_next       = TRAP_VECTOR;
                bad_addr_next = load_val;
                misalign_next = 1'b1;
            end else begin
                pc_next = load_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_VECTOR;
            pending_reg  <= '0;
            bad_addr_reg <= '0;
            misalign_reg <= 1'b0;
            sel_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            pending_reg  <= pending_next;
            bad_addr_reg <= bad_addr_next;
            misalign_reg <= misalign_next;
            sel_err_reg  <= sel_err_next;
        end
    end

    assign pc_o       = pc_reg;
    assign pc_valid_o = (state_reg != BOOT);
    assign pend_o     = (state_reg == PEND);
    assign misalign_o = misalign_reg;
    assign bad_addr_o = bad_addr_reg;
    assign sel_err_o  = sel_err_reg;

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit (NUM_SRC=3 so select 3 is illegal, JALR at select 2).
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [1:0]  sel_i;
    logic [63:0] tgt_flat_i;
`ifdef NPC_RVC_EN
    logic        is_rvc_i = 1'b0;
`endif
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        pc_valid_o;
    logic        pend_o;
    logic        misalign_o;
    logic [31:0] bad_addr_o;
    logic        sel_err_o;

    next_pc_unit #(
        .XLEN(32), .NUM_SRC(3), .SEL_W(2), .JALR_IDX(2),
        .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall_i(stall_i),
        .redirect_valid_i(redirect_valid_i),
        .sel_i(sel_i),
        .tgt_flat_i(tgt_flat_i),
`ifdef NPC_RVC_EN
        .is_rvc_i(is_rvc_i),
`endif
        .pc_o(pc_o),
        .pc_plus4_o(pc_plus4_o),
        .pc_valid_o(pc_valid_o),
        .pend_o(pend_o),
        .misalign_o(misalign_o),
        .bad_addr_o(bad_addr_o),
        .sel_err_o(sel_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        pend;
        logic        mis;
        logic        serr;
        logic [31:0] bad;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_txn    = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            $display("FAIL txn %0d %s: got %h, expected %h", n_txn, name, got, want);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic cyc(input logic rst, input logic st, input logic rv, input logic [1:0] sel,
                       input logic [31:0] t1, input logic [31:0] t2,
                       input logic [31:0] epc, input logic ev, input logic ep,
                       input logic em, input logic es, input logic [31:0] eb);
        reset            = rst;
        stall_i          = st;
        redirect_valid_i = rv;
        sel_i            = sel;
        tgt_flat_i       = {t2, t1};
        exp_q.push_back('{pc: epc, valid: ev, pend: ep, mis: em, serr: es, bad: eb});
        @(negedge clk);
    endtask

    // Monitor: every edge produces a new output set; compare it against the queue head.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: pc=%h valid=%b pend=%b mis=%b serr=%b bad=%h",
                         n_txn, pc_o, pc_valid_o, pend_o, misalign_o, sel_err_o, bad_addr_o);
                chk("pc_o", pc_o, mon_e.pc);
                chk("pc_plus4_o", pc_plus4_o, mon_e.pc + 32'd4);
                chk("pc_valid_o", 32'(pc_valid_o), 32'(mon_e.valid));
                chk("pend_o", 32'(pend_o), 32'(mon_e.pend));
                chk("misalign_o", 32'(misalign_o), 32'(mon_e.mis));
                chk("sel_err_o", 32'(sel_err_o), 32'(mon_e.serr));
                chk("bad_addr_o", bad_addr_o, mon_e.bad);
            end
        end
    end

    initial begin
        //  rst st rv sel t1            t2            pc            v  p  m  s  bad
        cyc(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
        // BOOT: redirect must be ignored
        cyc(0, 0, 1, 1, 32'h200,      32'h0,        32'h0,        1, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        32'h0,        32'h4,        1, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        32'h0,        32'h8,        1, 0, 0, 0, 32'h0);
        cyc(0, 0, 1, 1, 32'h200,      32'h0,        32'h200,      1, 0, 0, 0, 32'h0);
        // JALR: bit 0 cleared, then a bit-1 target traps
        cyc(0, 0, 1, 2, 32'h0,        32'h301,      32'h300,      1, 0, 0, 0, 32'h0);
        cyc(0, 0, 1, 2, 32'h0,        32'h302,      32'h100,      1, 0, 1, 0, 32'h302);
        cyc(0, 0, 0, 0, 32'h0,        32'h0,        32'h104,      1, 0, 0, 0, 32'h302);
        // stall: first redirect latched, second ignored, release input ignored
        cyc(0, 1, 1, 1, 32'h400,      32'h0,        32'h104,      1, 1, 0, 0, 32'h302);
        cyc(0, 1, 1, 2, 32'h0,        32'h800,      32'h104,      1, 1, 0, 0, 32'h302);
        cyc(0, 1, 0, 0, 32'h0,        32'h0,        32'h104,      1, 1, 0, 0, 32'h302);
        cyc(0, 0, 1, 1, 32'h900,      32'h0,        32'h400,      1, 0, 0, 0, 32'h302);
        cyc(0, 0, 0, 0, 32'h0,        32'h0,        32'h404,      1, 0, 0, 0, 32'h302);
        // illegal select: sequential advance plus one-cycle error pulse
        cyc(0, 0, 1, 3, 32'h0,        32'h0,        32'h408,      1, 0, 0, 1, 32'h302);
        cyc(0, 0, 0, 0, 32'h0,        32'h0,        32'h40c,      1, 0, 0, 0, 32'h302);
        // misaligned pending redirect traps on release
        cyc(0, 1, 1, 1, 32'h502,      32'h0,        32'h40c,      1, 1, 0, 0, 32'h302);
        cyc(0, 0, 0, 0, 32'h0,        32'h0,        32'h100,      1, 0, 1, 0, 32'h502);
        // wrap-around of the sequential path
        cyc(0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 1, 0, 0, 0, 32'h502);
        cyc(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 32'h502);
        // reset while pending discards the latched redirect
        cyc(0, 1, 1, 1, 32'h600,      32'h0,        32'h0,        1, 1, 0, 0, 32'h502);
        cyc(1, 1, 1, 1, 32'h600,      32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        32'h0,        32'h4,        1, 0, 0, 0, 32'h0);

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d queued entries, expected 0", exp_q.size());
        end else begin
            n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
